// File: rtl/minirv_pkg.sv
// Shared miniRV definitions: write-back source codes, forward-select
// encodings and the hazard scoreboard entry.
package minirv_pkg;

  localparam logic [2:0] WB_SEL_ALU  = 3'b000;
  localparam logic [2:0] WB_SEL_PC4  = 3'b001;
  localparam logic [2:0] WB_SEL_IMM  = 3'b010;
  localparam logic [2:0] WB_SEL_LOAD = 3'b011;
  localparam logic [2:0] WB_SEL_CSR  = 3'b100;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] wr;
    logic       is_load;
  } sb_entry_t;

  localparam int SB_ENTRY_W = $bits(sb_entry_t);
  localparam int SB_DEPTH   = 3;

endpackage

// File: rtl/hz_fwd_sel.sv
// Per-operand forwarding priority selector over the EX/MEM/WB scoreboard.
// Entry 0 of sb_i is EX, 1 is MEM, 2 is WB; the youngest matching writer wins.
module hz_fwd_sel
  import minirv_pkg::*;
(
  input  logic                             use_i,
  input  logic [4:0]                       rs_i,
  input  logic [SB_DEPTH*SB_ENTRY_W-1:0]   sb_i,
  output logic [1:0]                       sel_o
);

  sb_entry_t ent;
  logic      hit;

  always_comb begin
    sel_o = FWD_RF;
    hit   = 1'b0;
    ent   = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      ent = sb_i[i*SB_ENTRY_W +: SB_ENTRY_W];
      if (!hit && use_i && (rs_i != 5'd0) && ent.valid && ent.we && (ent.wr == rs_i)) begin
        hit = 1'b1;
        // A load still in EX has no data yet; the load-use stall covers it.
        if ((i == 0) && ent.is_load) sel_o = FWD_RF;
        else                         sel_o = 2'(i + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage miniRV core: shadow scoreboard,
// forwarding selects, load-use stall, redirect flush, freeze and perf counters.
module hazard_ctrl #(
  parameter int         CNT_W       = 16,
  parameter logic [2:0] WB_SEL_LOAD = 3'b011
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       id_rR1_i,
  input  logic [4:0]       id_rR2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             id_rf_we_i,
  input  logic [4:0]       id_wR_i,
  input  logic [2:0]       id_wb_sel_i,
  input  logic             id_redirect_i,
  input  logic             mem_busy_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             bubble_ex_o,
  output logic             flush_ifid_o,
  output logic             freeze_o,
  output logic [1:0]       fwd_rs1_sel_o,
  output logic [1:0]       fwd_rs2_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  import minirv_pkg::*;

  sb_entry_t        ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic ex_writer, rs1_hit, rs2_hit, lu, frz, bubble, flush;
  logic [SB_DEPTH*SB_ENTRY_W-1:0] sb_flat;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  // Reset gates the freeze/flush paths so every output reads 0 while rst_n_i is low.
  always_comb begin
    ex_writer = ex_q.valid & ex_q.we & (ex_q.wr != 5'd0);
    rs1_hit   = id_use_rs1_i & (id_rR1_i != 5'd0) & (id_rR1_i == ex_q.wr);
    rs2_hit   = id_use_rs2_i & (id_rR2_i != 5'd0) & (id_rR2_i == ex_q.wr);
    lu        = ex_writer & ex_q.is_load & (rs1_hit | rs2_hit);
    frz       = mem_busy_i & rst_n_i;
    bubble    = lu & ~frz;
    flush     = id_redirect_i & ~lu & ~frz & rst_n_i;
  end

  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!frz) begin
      wb_d          = mem_q;
      mem_d         = ex_q;
      ex_d.valid    = ~bubble;
      ex_d.we       = id_rf_we_i;
      ex_d.wr       = id_wR_i;
      ex_d.is_load  = (id_wb_sel_i == WB_SEL_LOAD);
      stall_cnt_d   = sat_inc(stall_cnt_q, lu);
      flush_cnt_d   = sat_inc(flush_cnt_q, flush);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign sb_flat = {wb_q, mem_q, ex_q};

  hz_fwd_sel u_fwd_rs1 (
    .use_i (id_use_rs1_i),
    .rs_i  (id_rR1_i),
    .sb_i  (sb_flat),
    .sel_o (fwd_rs1_sel_o)
  );

  hz_fwd_sel u_fwd_rs2 (
    .use_i (id_use_rs2_i),
    .rs_i  (id_rR2_i),
    .sb_i  (sb_flat),
    .sel_o (fwd_rs2_sel_o)
  );

  assign stall_if_o   = lu | frz;
  assign stall_id_o   = lu | frz;
  assign bubble_ex_o  = bubble;
  assign flush_ifid_o = flush;
  assign freeze_o     = frz;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a pipeline-occupancy reference model.
module tb_hazard_ctrl;

  localparam int             CNT_W = 6;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam int             OW    = 9 + 2 * CNT_W;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] r1 = '0, r2 = '0, wr = '0;
  logic       u1 = 1'b0, u2 = 1'b0, we = 1'b0, redir = 1'b0, busy = 1'b0;
  logic [2:0] ws = '0;

  logic             stall_if, stall_id, bubble, flush, freeze;
  logic [1:0]       sel1, sel2;
  logic [CNT_W-1:0] scnt, fcnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .WB_SEL_LOAD(3'b011)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .id_rR1_i      (r1),
    .id_rR2_i      (r2),
    .id_use_rs1_i  (u1),
    .id_use_rs2_i  (u2),
    .id_rf_we_i    (we),
    .id_wR_i       (wr),
    .id_wb_sel_i   (ws),
    .id_redirect_i (redir),
    .mem_busy_i    (busy),
    .stall_if_o    (stall_if),
    .stall_id_o    (stall_id),
    .bubble_ex_o   (bubble),
    .flush_ifid_o  (flush),
    .freeze_o      (freeze),
    .fwd_rs1_sel_o (sel1),
    .fwd_rs2_sel_o (sel2),
    .stall_cnt_o   (scnt),
    .flush_cnt_o   (fcnt)
  );

  wire [OW-1:0] obs = {stall_if, stall_id, bubble, flush, freeze, sel1, sel2, scnt, fcnt};

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: occupancy of the three stages behind ID (0=EX, 1=MEM, 2=WB).
  bit         m_v[3];
  bit         m_we[3];
  logic [4:0] m_rd[3];
  bit         m_ld[3];
  int         m_sc, m_fc;
  bit         e_lu, e_bub, e_flush, e_stall;
  logic [OW-1:0] exp_vec;
  logic [1:0] fwd_code[3] = '{2'b01, 2'b10, 2'b11};

  function automatic bit m_writer(input int s);
    return m_v[s] && m_we[s] && (m_rd[s] != 5'd0);
  endfunction

  function automatic logic [1:0] m_sel(input logic u, input logic [4:0] rs);
    if (!u || rs == 5'd0) return 2'b00;
    for (int s = 0; s < 3; s++)
      if (m_writer(s) && m_rd[s] == rs)
        return (s == 0 && m_ld[0]) ? 2'b00 : fwd_code[s];
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      m_v[s] = 0; m_we[s] = 0; m_rd[s] = '0; m_ld[s] = 0;
    end
    m_sc = 0; m_fc = 0;
  endtask

  task automatic model_eval();
    e_lu    = m_writer(0) && m_ld[0] &&
              ((u1 && r1 != 0 && r1 == m_rd[0]) || (u2 && r2 != 0 && r2 == m_rd[0]));
    e_stall = e_lu || busy;
    e_bub   = e_lu && !busy;
    e_flush = redir && !e_lu && !busy;
    exp_vec = {e_stall, e_stall, e_bub, e_flush, busy, m_sel(u1, r1), m_sel(u2, r2),
               CNT_W'(m_sc), CNT_W'(m_fc)};
  endtask

  task automatic model_update();
    if (!busy) begin
      for (int s = 2; s > 0; s--) begin
        m_v[s] = m_v[s-1]; m_we[s] = m_we[s-1]; m_rd[s] = m_rd[s-1]; m_ld[s] = m_ld[s-1];
      end
      m_v[0] = !e_bub; m_we[0] = we; m_rd[0] = wr; m_ld[0] = (ws == 3'b011);
      if (e_lu && m_sc < int'(CMAX)) m_sc++;
      if (e_flush && m_fc < int'(CMAX)) m_fc++;
    end
  endtask

  task automatic set_in(input logic [4:0] a1, input logic [4:0] a2, input logic au1,
                        input logic au2, input logic awe, input logic [4:0] awr,
                        input logic [2:0] aws, input logic ard, input logic abz);
    r1 = a1; r2 = a2; u1 = au1; u2 = au2; we = awe; wr = awr; ws = aws;
    redir = ard; busy = abz;
  endtask

  task automatic nop();
    set_in(0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic drain();
    repeat (3) begin nop(); tick(); end
  endtask

  task automatic test_reset();
    nop();
    #2;
    n_chk++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_async: got %h expected 0", obs); end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_held: got %h expected 0", obs); end
    rst_n = 1'b1;
    model_reset();
    settle();
    n_chk++;
    if (obs !== exp_vec) begin n_fail++; $display("FAIL reset_release: got %h expected %h", obs, exp_vec); end
  endtask

  task automatic test_alu_fwd();
    set_in(0, 0, 0, 0, 1, 5'd5, 3'b000, 0, 0); tick();
    set_in(5'd5, 0, 1, 0, 0, 0, 3'b000, 0, 0); settle();
    n_chk++;
    if (obs !== exp_vec) begin n_fail++; $display("FAIL alu_fwd_vec: got %h expected %h", obs, exp_vec); end
    n_chk++;
    if (sel1 !== 2'b01 || stall_if !== 1'b0) begin
      n_fail++; $display("FAIL alu_fwd_sel: got sel=%b stall=%b expected sel=01 stall=0", sel1, stall_if);
    end
    tick();
    n_chk++;
    if (scnt !== '0) begin n_fail++; $display("FAIL alu_fwd_cnt: got %0d expected 0", scnt); end
  endtask

  task automatic test_load_use();
    drain();
    set_in(0, 0, 0, 0, 1, 5'd7, 3'b011, 0, 0); tick();
    set_in(0, 5'd7, 0, 1, 0, 0, 3'b000, 0, 0); settle();
    n_chk++;
    if ({stall_if, stall_id, bubble} !== 3'b111) begin
      n_fail++; $display("FAIL lu_stall: got %b expected 111", {stall_if, stall_id, bubble});
    end
    tick(); settle();
    n_chk++;
    if (scnt !== 1 || sel2 !== 2'b10 || stall_if !== 1'b0) begin
      n_fail++; $display("FAIL lu_after: got cnt=%0d sel=%b stall=%b expected cnt=1 sel=10 stall=0", scnt, sel2, stall_if);
    end
    n_chk++;
    if (obs !== exp_vec) begin n_fail++; $display("FAIL lu_after_vec: got %h expected %h", obs, exp_vec); end
    tick();
  endtask

  task automatic test_priority_x0();
    drain();
    set_in(0, 0, 0, 0, 1, 5'd3, 3'b000, 0, 0); tick();
    set_in(0, 0, 0, 0, 1, 5'd3, 3'b010, 0, 0); tick();
    set_in(5'd3, 5'd3, 1, 1, 1, 5'd0, 3'b000, 0, 0); settle();
    n_chk++;
    if (sel1 !== 2'b01 || sel2 !== 2'b01) begin
      n_fail++; $display("FAIL prio_ex_mem: got %b/%b expected 01/01", sel1, sel2);
    end
    tick();
    set_in(5'd0, 5'd0, 1, 1, 0, 0, 3'b000, 0, 0); settle();
    n_chk++;
    if (sel1 !== 2'b00 || sel2 !== 2'b00) begin
      n_fail++; $display("FAIL x0_sel: got %b/%b expected 00/00", sel1, sel2);
    end
    set_in(5'd3, 5'd3, 0, 1, 0, 0, 3'b000, 0, 0); settle();
    n_chk++;
    if (sel1 !== 2'b00 || sel2 !== 2'b10) begin
      n_fail++; $display("FAIL unused_sel: got %b/%b expected 00/10", sel1, sel2);
    end
    tick();
  endtask

  task automatic test_redirect_lu();
    drain();
    set_in(0, 0, 0, 0, 1, 5'd7, 3'b011, 0, 0); tick();
    set_in(5'd7, 0, 1, 0, 0, 0, 3'b000, 1, 0); settle();
    n_chk++;
    if (flush !== 1'b0 || stall_if !== 1'b1) begin
      n_fail++; $display("FAIL redir_lu: got flush=%b stall=%b expected flush=0 stall=1", flush, stall_if);
    end
    tick(); settle();
    n_chk++;
    if (flush !== 1'b1 || sel1 !== 2'b10) begin
      n_fail++; $display("FAIL redir_held: got flush=%b sel=%b expected flush=1 sel=10", flush, sel1);
    end
    tick();
    n_chk++;
    if (fcnt !== 1) begin n_fail++; $display("FAIL redir_cnt: got %0d expected 1", fcnt); end
  endtask

  task automatic test_freeze();
    drain();
    set_in(0, 0, 0, 0, 1, 5'd9, 3'b011, 0, 0); tick();
    for (int c = 0; c < 3; c++) begin
      set_in(5'd9, 0, 1, 0, 0, 0, 3'b000, 1, 1); settle();
      n_chk++;
      if ({freeze, bubble, stall_if, flush} !== 4'b1010) begin
        n_fail++; $display("FAIL freeze_out: got %b expected 1010", {freeze, bubble, stall_if, flush});
      end
      n_chk++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL freeze_vec: got %h expected %h", obs, exp_vec); end
      tick();
    end
    set_in(5'd9, 0, 1, 0, 0, 0, 3'b000, 0, 0); settle();
    n_chk++;
    if ({freeze, bubble, stall_if} !== 3'b011) begin
      n_fail++; $display("FAIL freeze_release: got %b expected 011", {freeze, bubble, stall_if});
    end
    tick(); settle();
    n_chk++;
    if (sel1 !== 2'b10 || obs !== exp_vec) begin
      n_fail++; $display("FAIL freeze_after: got %h expected %h", obs, exp_vec);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [2:0] s;
      s = ($urandom_range(0, 9) < 4) ? 3'b011 : 3'($urandom_range(0, 2));
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 3)), s,
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
      settle();
      n_chk++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL random c=%0d: got %h expected %h", c, obs, exp_vec); end
      tick();
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < int'(CMAX) + 4; k++) begin
      set_in(0, 0, 0, 0, 1, 5'd7, 3'b011, 0, 0); tick();
      set_in(0, 5'd7, 0, 1, 0, 0, 3'b000, 0, 0); tick();
    end
    n_chk++;
    if (scnt !== CMAX) begin n_fail++; $display("FAIL stall_sat: got %0d expected %0d", scnt, CMAX); end
    for (int k = 0; k < int'(CMAX) + 4; k++) begin
      set_in(0, 0, 0, 0, 0, 0, 3'b000, 1, 0); tick();
    end
    n_chk++;
    if (fcnt !== CMAX) begin n_fail++; $display("FAIL flush_sat: got %0d expected %0d", fcnt, CMAX); end
    set_in(0, 0, 0, 0, 1, 5'd7, 3'b011, 0, 0); tick();
    set_in(0, 5'd7, 0, 1, 0, 0, 3'b000, 0, 0); settle();
    n_chk++;
    if (stall_if !== 1'b1) begin n_fail++; $display("FAIL sat_stall_live: got %b expected 1", stall_if); end
    tick();
    n_chk++;
    if (scnt !== CMAX) begin n_fail++; $display("FAIL stall_no_wrap: got %0d expected %0d", scnt, CMAX); end
  endtask

  task automatic test_reset_mid();
    set_in(0, 0, 0, 0, 1, 5'd7, 3'b011, 0, 0); tick();
    set_in(5'd7, 0, 1, 0, 0, 0, 3'b000, 0, 0); settle();
    n_chk++;
    if (stall_if !== 1'b1 || scnt !== CMAX) begin
      n_fail++; $display("FAIL pre_reset: got stall=%b cnt=%0d expected 1/%0d", stall_if, scnt, CMAX);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_mid: got %h expected 0", obs); end
    @(posedge clk); #1;
    n_chk++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_mid_edge: got %h expected 0", obs); end
    rst_n = 1'b1;
    model_reset();
    nop(); tick(); settle();
    n_chk++;
    if (obs !== exp_vec) begin n_fail++; $display("FAIL post_reset: got %h expected %h", obs, exp_vec); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    model_reset();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_priority_x0();
    test_redirect_lu();
    test_freeze();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
